// File: rtl/phy_pkg.sv
// Shared PHY lane definitions: serializer state encoding and the K28.5 comma
// character that the Rx aligner also searches for.
package phy_pkg;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } tx_state_e;

  localparam logic [7:0] K28_5 = 8'hBC;

endpackage

// File: rtl/tx_serializer_if.sv
// Parallel word handshake into the transmit serializer.
interface tx_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);

endinterface

// File: rtl/tx_serializer.sv
// MSB-first parallel-to-serial transmitter with a post-reset comma training
// burst and idle fill whenever no word is offered on a load slot.
module tx_serializer
  import phy_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] IDLE   = WIDTH'(K28_5),
  parameter int               N_SYNC = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enb,
  tx_serializer_if.slave tx,
  output logic           data_out,
  output logic           byte_strobe,
  output logic           active
);

  localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SYNC_W = $clog2(N_SYNC + 1);

  tx_state_e          state_q,       state_d;
  logic [CNT_W-1:0]   bit_cnt_q,     bit_cnt_d;
  logic [SYNC_W-1:0]  sync_cnt_q,    sync_cnt_d;
  logic [WIDTH-1:0]   shreg_q,       shreg_d;
  logic               data_out_q,    data_out_d;
  logic               byte_strobe_q, byte_strobe_d;
  logic               active_q,      active_d;

  logic [WIDTH-1:0]   word;
  logic               is_load;
  logic               is_last;

  function automatic logic [SYNC_W-1:0] sat_inc(input logic [SYNC_W-1:0] v);
    return (v == SYNC_W'(N_SYNC)) ? v : v + SYNC_W'(1);
  endfunction

  assign is_load      = (bit_cnt_q == '0);
  assign is_last      = (bit_cnt_q == CNT_W'(WIDTH - 1));
  assign tx.ready_out = enb && (state_q == ACTIVE) && is_load;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    sync_cnt_d    = sync_cnt_q;
    shreg_d       = shreg_q;
    data_out_d    = data_out_q;
    byte_strobe_d = byte_strobe_q;
    word          = IDLE;

    if (enb) begin
      bit_cnt_d = is_last ? '0 : bit_cnt_q + CNT_W'(1);
      if (is_load) begin
        // Data only replaces the comma once training is complete.
        if (state_q == ACTIVE && tx.valid_in) word = tx.data_in;
        data_out_d    = word[WIDTH-1];
        shreg_d       = word << 1;
        byte_strobe_d = 1'b1;
        if (state_q == SYNC) sync_cnt_d = sat_inc(sync_cnt_q);
      end else begin
        data_out_d    = shreg_q[WIDTH-1];
        shreg_d       = shreg_q << 1;
        byte_strobe_d = 1'b0;
      end
      if (state_q == SYNC && is_last && sync_cnt_q == SYNC_W'(N_SYNC)) state_d = ACTIVE;
    end

    active_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SYNC;
      bit_cnt_q     <= '0;
      sync_cnt_q    <= '0;
      shreg_q       <= '0;
      data_out_q    <= 1'b0;
      byte_strobe_q <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      sync_cnt_q    <= sync_cnt_d;
      shreg_q       <= shreg_d;
      data_out_q    <= data_out_d;
      byte_strobe_q <= byte_strobe_d;
      active_q      <= active_d;
    end
  end

  assign data_out    = data_out_q;
  assign byte_strobe = byte_strobe_q;
  assign active      = active_q;

endmodule

// File: tb/tb_tx_serializer.sv
// Bench for tx_serializer: scenario tasks plus a word-level reference model
// indexed by the number of enabled edges since reset.
module tb_tx_serializer;

  localparam int         W    = 8;
  localparam int         NS   = 4;
  localparam logic [7:0] IDLE = 8'hBC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enb = 1'b0;
  logic data_out, byte_strobe, active;

  int n_tests = 0;
  int n_fail  = 0;

  tx_serializer_if #(.WIDTH(W)) bus ();

  tx_serializer #(.WIDTH(W), .IDLE(IDLE), .N_SYNC(NS)) dut (
    .clk         (clk),
    .rst         (rst),
    .enb         (enb),
    .tx          (bus),
    .data_out    (data_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  always #5 clk = ~clk;

  // Reference model: edge k of a word slot carries bit (W-1 - k%W) of the slot word
  int         m_k;
  logic       m_dout, m_strb, m_act;
  logic [7:0] m_word;
  logic [7:0] m_next;
  logic       m_ready;

  assign m_next  = (m_k >= NS * W && bus.valid_in) ? bus.data_in : IDLE;
  assign m_ready = enb && (m_k >= NS * W) && (m_k % W == 0);

  always @(posedge clk) begin
    if (rst) begin
      m_k    <= 0;
      m_dout <= 1'b0;
      m_strb <= 1'b0;
      m_act  <= 1'b0;
      m_word <= 8'h00;
    end else if (enb) begin
      if (m_k % W == 0) begin
        m_word <= m_next;
        m_dout <= m_next[W-1];
      end else begin
        m_dout <= m_word[W-1-(m_k % W)];
      end
      m_strb <= (m_k % W == 0);
      if (m_k >= NS * W - 1) m_act <= 1'b1;
      m_k <= m_k + 1;
    end
  end

  task automatic drive(input logic e, input logic v, input logic [7:0] d);
    enb          = e;
    bus.valid_in = v;
    bus.data_in  = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'hFF);
    tick();
    tick();
    n_tests++;
    if (data_out !== 1'b0) begin n_fail++; $display("FAIL reset_data_out got %b want 0", data_out); end
    n_tests++;
    if (byte_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got %b want 0", byte_strobe); end
    n_tests++;
    if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", active); end
    n_tests++;
    if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", bus.ready_out); end
    rst = 1'b0;
  endtask

  task automatic test_sync();
    logic [7:0] kpat = 8'hBC;
    for (int i = 0; i < 48; i++) begin
      drive(1'b1, 1'b0, 8'($urandom));
      n_tests++;
      if (bus.ready_out !== (i >= 32 && i % 8 == 0)) begin
        n_fail++; $display("FAIL sync_ready edge %0d got %b want %b", i, bus.ready_out, (i >= 32 && i % 8 == 0));
      end
      tick();
      n_tests++;
      if (data_out !== kpat[7-(i%8)]) begin
        n_fail++; $display("FAIL sync_data edge %0d got %b want %b", i, data_out, kpat[7-(i%8)]);
      end
      n_tests++;
      if (byte_strobe !== (i % 8 == 0)) begin
        n_fail++; $display("FAIL sync_strobe edge %0d got %b want %b", i, byte_strobe, (i % 8 == 0));
      end
      n_tests++;
      if (active !== (i >= 31)) begin
        n_fail++; $display("FAIL sync_active edge %0d got %b want %b", i, active, (i >= 31));
      end
      n_tests++;
      if (data_out !== m_dout) begin
        n_fail++; $display("FAIL sync_model edge %0d got %b want %b", i, data_out, m_dout);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream = '0;
    int          rdy_cnt = 0;
    logic [7:0]  d;
    logic        acc;
    for (int i = 0; i < 16; i++) begin
      d = (i < 8) ? 8'hA5 : 8'h3C;
      drive(1'b1, 1'b1, d);
      acc = bus.ready_out;
      if (acc) rdy_cnt++;
      tick();
      stream = {stream[14:0], data_out};
      if (acc) begin
        n_tests++;
        if (byte_strobe !== 1'b1 || data_out !== d[7]) begin
          n_fail++; $display("FAIL b2b_msb_after_accept edge %0d got strobe=%b bit=%b want strobe=1 bit=%b", i, byte_strobe, data_out, d[7]);
        end
      end
    end
    drive(1'b1, 1'b0, 8'h00);
    n_tests++;
    if (rdy_cnt != 2) begin n_fail++; $display("FAIL b2b_ready_count got %0d want 2", rdy_cnt); end
    n_tests++;
    if (stream !== 16'hA53C) begin n_fail++; $display("FAIL b2b_stream got %h want a53c", stream); end
  endtask

  task automatic test_enb_toggle();
    logic [7:0] bits = '0;
    int         got = 0;
    int         guard = 0;
    logic       e, pd, ps, pa;
    while (got < 8 && guard < 400) begin
      e = 1'($urandom % 2);
      drive(e, 1'b1, 8'hC3);
      pd = data_out; ps = byte_strobe; pa = active;
      tick();
      guard++;
      if (e) begin
        bits = {bits[6:0], data_out};
        got++;
        n_tests++;
        if (byte_strobe !== (got == 1)) begin
          n_fail++; $display("FAIL enb_strobe bit %0d got %b want %b", got, byte_strobe, (got == 1));
        end
      end else begin
        n_tests++;
        if (data_out !== pd || byte_strobe !== ps || active !== pa) begin
          n_fail++; $display("FAIL enb_hold got %b%b%b want %b%b%b", data_out, byte_strobe, active, pd, ps, pa);
        end
      end
    end
    drive(1'b1, 1'b0, 8'h00);
    n_tests++;
    if (got != 8) begin n_fail++; $display("FAIL enb_timeout got %0d bits want 8", got); end
    n_tests++;
    if (bits !== 8'hC3) begin n_fail++; $display("FAIL enb_bits got %h want c3", bits); end
  endtask

  task automatic test_alternate();
    logic [31:0] stream = '0;
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 8; b++) begin
        drive(1'b1, (s % 2 == 0), 8'h01);
        tick();
        stream = {stream[30:0], data_out};
      end
    end
    n_tests++;
    if (stream !== 32'h01BC01BC) begin n_fail++; $display("FAIL alt_stream got %h want 01bc01bc", stream); end
  endtask

  task automatic test_rst_mid();
    logic [7:0] kpat = 8'hBC;
    logic [7:0] d;
    int         early = 0;
    drive(1'b1, 1'b1, 8'hFF);
    n_tests++;
    if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_accept got %b want 1", bus.ready_out); end
    tick();
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 8'h00); tick(); end
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'hFF);
    tick();
    n_tests++;
    if ({data_out, byte_strobe, active, bus.ready_out} !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_outputs got %b want 0000", {data_out, byte_strobe, active, bus.ready_out});
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      drive(1'b1, 1'b1, d);
      if (i < 32 && bus.ready_out) early++;
      if (i == 32) begin
        n_tests++;
        if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_first_ready got %b want 1", bus.ready_out); end
      end
      tick();
      if (i < 32) begin
        n_tests++;
        if (data_out !== kpat[7-(i%8)]) begin
          n_fail++; $display("FAIL rstmid_resync edge %0d got %b want %b", i, data_out, kpat[7-(i%8)]);
        end
      end else if (i == 32) begin
        n_tests++;
        if (data_out !== d[7]) begin n_fail++; $display("FAIL rstmid_data_msb got %b want %b", data_out, d[7]); end
      end
    end
    n_tests++;
    if (early != 0) begin n_fail++; $display("FAIL rstmid_early_ready got %0d want 0", early); end
  endtask

  task automatic test_data_change();
    logic [7:0] wq[$];
    logic [7:0] sr = '0;
    logic [7:0] w, d;
    for (int i = 0; i < 64; i++) begin
      d = 8'($urandom);
      drive(1'b1, 1'b1, d);
      if (bus.ready_out) wq.push_back(d);
      tick();
      sr = {sr[6:0], data_out};
      if (i % 8 == 7) begin
        n_tests++;
        if (wq.size() == 0) begin
          n_fail++; $display("FAIL chg_no_accept slot %0d got 0 words want 1", i / 8);
        end else begin
          w = wq.pop_front();
          if (sr !== w) begin n_fail++; $display("FAIL chg_word slot %0d got %h want %h", i / 8, sr, w); end
        end
      end
    end
  endtask

  task automatic test_random();
    logic e, v;
    for (int i = 0; i < 300; i++) begin
      e = ($urandom % 4) != 0;
      v = 1'($urandom % 2);
      drive(e, v, 8'($urandom));
      n_tests++;
      if (bus.ready_out !== m_ready) begin
        n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, bus.ready_out, m_ready);
      end
      tick();
      n_tests++;
      if ({data_out, byte_strobe, active} !== {m_dout, m_strb, m_act}) begin
        n_fail++; $display("FAIL rnd_outputs cyc %0d got %b%b%b want %b%b%b", i, data_out, byte_strobe, active, m_dout, m_strb, m_act);
      end
    end
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    test_reset();
    test_sync();
    test_back_to_back();
    test_enb_toggle();
    test_alternate();
    test_rst_mid();
    test_data_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_serializer.md
# tx_serializer

Transmit-side parallel-to-serial converter for the PHY lane; it is the counterpart of the receive-side deserializer fed by the Rx clock generator. It accepts bytes through a valid/ready handshake, shifts them out MSB-first at one bit per enabled `clk` cycle, and emits a byte-boundary strobe. After reset it transmits a training burst of idle/comma characters so the far-end receiver can lock its word alignment. When no data is offered, it fills the line with the idle character.

## Interface
- `WIDTH`, 8: bits per word; must be ≥ 2.
- `IDLE`, 8'hBC: idle/comma word, `WIDTH` bits, sent during sync and whenever no data is accepted.
- `N_SYNC`, 4: number of idle words sent after reset before data is accepted; must be ≥ 1.
- `clk`  in  1  clock; reset is `rst`, synchronous, active-high, on clock `clk`.
- `rst`  in  1  synchronous active-high reset.
- `enb`  in  1  bit-rate enable; when low, all state and outputs hold.
- `data_in`  in  WIDTH  word to transmit.
- `valid_in`  in  1  `data_in` is valid.
- `ready_out`  out  1  combinational; word accepted on an edge where `valid_in & ready_out`.
- `data_out`  out  1  registered serial bit.
- `byte_strobe`  out  1  registered; high while `data_out` carries the MSB of a word.
- `active`  out  1  registered; high once sync is done (state ACTIVE).

## Operation
- Registers: `shreg[WIDTH-1:0]`, `bit_cnt` (clog2 WIDTH, wraps at WIDTH-1→0), `sync_cnt` (counts to N_SYNC), `state` ∈ {SYNC, ACTIVE}.
- Reset values: `state`=SYNC, `bit_cnt`=0, `sync_cnt`=0, `shreg`=0. Outputs: `data_out`=0, `byte_strobe`=0, `active`=0. `ready_out`=0 because state≠ACTIVE.
- Enabled edge with `bit_cnt`==0 (load):
  - The load word is `data_in` if state=ACTIVE and `valid_in`=1; otherwise it is `IDLE`.
  - `data_out`←word[WIDTH-1], `shreg`←word<<1, `byte_strobe`←1.
  - In SYNC, `sync_cnt` increments, saturating at N_SYNC.
- Enabled edge with `bit_cnt`≠0: `data_out`←`shreg[WIDTH-1]`, `shreg`←`shreg`<<1, `byte_strobe`←0.
- Every enabled edge: `bit_cnt` increments modulo WIDTH.
- SYNC→ACTIVE: on the enabled edge where `bit_cnt`==WIDTH-1 and `sync_cnt`==N_SYNC, state←ACTIVE and `active`←1.
- ACTIVE is terminal until `rst`.
- `ready_out` = `enb` & (state==ACTIVE) & (`bit_cnt`==0). Only one word can be accepted per WIDTH enabled cycles.
- A word is never truncated: `valid_in` or `data_in` changing mid-word has no effect on the bits in flight.
- `rst` mid-word: the word in flight is abandoned and the full sync burst restarts.
- `enb`=0: `ready_out`=0 and all registers hold, including `data_out` and `byte_strobe`. No bit is skipped or duplicated in the stream of enabled cycles.

## Timing
- Accept edge n → MSB on `data_out` after edge n; LSB after the (WIDTH-1)-th subsequent enabled edge (n+7 for default WIDTH with `enb`=1).
- `byte_strobe` is high for exactly one enabled cycle per word, aligned with the MSB.
- With `enb`=1 continuously after reset release, enabled edges are numbered from 0:
  - idle words load on edges 0, 8, 16, 24;
  - `active` rises after edge 31;
  - `ready_out` is first high before edge 32.
- Back-to-back words: `valid_in` held high gives continuous data with no gap bits.

## Structure
- Shared package `phy_pkg` holds:
  - state encoding localparams SYNC=1'b0, ACTIVE=1'b1;
  - the default comma `K28_5`=8'hBC, shared with the Rx aligner.
- Optional sub-module `piso_shreg`: a loadable MSB-first shift register with a hold enable. The FSM and counters stay in `tx_serializer`.

## Test plan
- Reset, then `enb`=1 and `valid_in`=0 for 48 cycles:
  - `data_out` repeats 10111100 six times;
  - `byte_strobe` is high every 8th cycle;
  - `active` rises after edge 31.
- After sync, present 8'hA5 then 8'h3C back-to-back → serial stream 10100101 00111100; `ready_out` is high exactly twice; each accepted word's MSB appears the cycle after its accept edge.
- Toggle `enb` at random (≈50%) during transmission of 8'hC3 → the enabled-cycle bit sequence is 11000011, and outputs hold when `enb`=0.
- During ACTIVE, `valid_in`=1 only on every other word slot with data 8'h01 → stream alternates 00000001 and 10111100.
- Assert `rst` at bit 4 of 8'hFF → all outputs 0 and `ready_out`=0 the following cycle; after release, the 4 idle words are sent again before the next accept.
- `valid_in` held high with `data_in` changing every cycle → only the values present on load edges are transmitted, and each is transmitted intact.
